// File: rtl/move_list_fifo.sv
// Multi-port move-word FIFO: up to NUM_WR writes per cycle, one FWFT read.
// Accepted words land in port order; refused writes set a sticky overflow.
module move_list_fifo #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 16,
    parameter int NUM_WR = 2,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [NUM_WR-1:0]        wr_accepted,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic [ADDR_W:0]          count,
    output logic                     full,
    output logic                     overflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] slot_addr [NUM_WR];
    logic [NUM_WR-1:0] acc;
    logic [NUM_WR-1:0] drop;
    logic [ADDR_W:0]   n_acc;
    logic              pop;
    int                space_i;
    int                acc_n;

    assign rd_valid    = (count != '0);
    assign full        = (count == (ADDR_W+1)'(DEPTH));
    assign rd_data     = mem[rd_ptr];
    assign wr_accepted = acc;
    assign pop         = resetn && !flush && rd_valid && rd_ready;

    // Grant requested channels in index order while free slots remain;
    // accepted words pack into consecutive slots from the write pointer.
    always_comb begin
        acc     = '0;
        drop    = '0;
        acc_n   = 0;
        space_i = DEPTH - int'(count);
        for (int i = 0; i < NUM_WR; i++) begin
            slot_addr[i] = wr_ptr + acc_n[ADDR_W-1:0];
            if (wr_en[i]) begin
                if (acc_n < space_i) begin
                    acc[i] = 1'b1;
                    acc_n  = acc_n + 1;
                end else begin
                    drop[i] = 1'b1;
                end
            end
        end
        if (!resetn || flush) begin
            acc   = '0;
            drop  = '0;
            acc_n = 0;
        end
        n_acc = acc_n[ADDR_W:0];
    end

    // Storage array: no reset, only accepted words are written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WR; i++) begin
            if (acc[i]) begin
                mem[slot_addr[i]] <= wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointers, occupancy and sticky overflow; reset beats flush.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + n_acc[ADDR_W-1:0];
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + n_acc - {{ADDR_W{1'b0}}, pop};
            if (|drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_move_list_fifo.sv
// Directed and scoreboarded checks for move_list_fifo.
// Default parameters: DATA_W=48, DEPTH=16, NUM_WR=2.
module tb_move_list_fifo;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic [1:0]  wr_en;
    logic [95:0] wr_data;
    logic [1:0]  wr_accepted;
    logic        rd_valid;
    logic        rd_ready;
    logic [47:0] rd_data;
    logic [4:0]  count;
    logic        full;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    logic [47:0] q[$];
    logic [47:0] d0;
    logic [47:0] d1;
    int          mspace;
    int          macc;
    bit          mpop;

    always #5 clk = ~clk;

    move_list_fifo dut (
        .clk(clk),
        .resetn(resetn),
        .flush(flush),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_accepted(wr_accepted),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .count(count),
        .full(full),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] en, input logic [47:0] a,
                      input logic [47:0] b);
        wr_en   = en;
        wr_data = {b, a};
    endtask

    initial begin
        resetn   = 1'b0;
        flush    = 1'b0;
        rd_ready = 1'b0;
        wr(2'b00, '0, '0);
        tick();
        tick();
        resetn = 1'b1;

        // reset then idle
        for (int i = 0; i < 5; i++) begin
            chk("idle_count", count, 0);
            chk("idle_valid", rd_valid, 0);
            chk("idle_full", full, 0);
            chk("idle_ovf", overflow, 0);
            tick();
        end

        // two words in one cycle, then pop both
        wr(2'b11, 48'h1, 48'h2);
        rd_ready = 1'b1;
        #1;
        chk("dual_acc", wr_accepted, 2'b11);
        tick();
        wr(2'b00, '0, '0);
        chk("dual_cnt2", count, 2);
        chk("dual_rd1", rd_data, 48'h1);
        tick();
        chk("dual_cnt1", count, 1);
        chk("dual_rd2", rd_data, 48'h2);
        tick();
        chk("dual_cnt0", count, 0);
        chk("dual_empty", rd_valid, 0);
        rd_ready = 1'b0;

        // fill to 15
        for (int i = 0; i < 7; i++) begin
            wr(2'b11, 48'(100 + 2*i), 48'(101 + 2*i));
            tick();
        end
        wr(2'b01, 48'd114, '0);
        tick();
        chk("fill15", count, 15);
        chk("fill15_full", full, 0);

        // one slot left: ch0 kept, ch1 dropped
        wr(2'b11, 48'hA0A0, 48'hB0B0);
        #1;
        chk("part_acc", wr_accepted, 2'b01);
        tick();
        chk("part_cnt", count, 16);
        chk("part_full", full, 1);
        chk("part_ovf", overflow, 1);

        // full: pop proceeds, write refused
        wr(2'b01, 48'hC0C0, '0);
        rd_ready = 1'b1;
        #1;
        chk("fullpp_acc", wr_accepted, 2'b00);
        chk("fullpp_head", rd_data, 48'd100);
        tick();
        wr(2'b00, '0, '0);
        chk("fullpp_cnt", count, 15);
        chk("fullpp_ovf", overflow, 1);
        chk("fullpp_full", full, 0);

        // drain the remaining 15; A comes last
        for (int i = 0; i < 14; i++) begin
            chk("drain", rd_data, 48'(101 + i));
            tick();
        end
        chk("drain_last", rd_data, 48'hA0A0);
        tick();
        chk("drain_cnt", count, 0);
        chk("drain_valid", rd_valid, 0);
        rd_ready = 1'b0;

        // five words then flush
        wr(2'b11, 48'd1, 48'd2);
        tick();
        wr(2'b11, 48'd3, 48'd4);
        tick();
        wr(2'b01, 48'd5, '0);
        tick();
        chk("pre_flush", count, 5);
        flush    = 1'b1;
        rd_ready = 1'b1;
        wr(2'b11, 48'd6, 48'd7);
        #1;
        chk("flush_acc", wr_accepted, 2'b00);
        tick();
        flush    = 1'b0;
        rd_ready = 1'b0;
        wr(2'b00, '0, '0);
        chk("flush_cnt", count, 0);
        chk("flush_valid", rd_valid, 0);
        chk("flush_ovf", overflow, 0);

        // random traffic against a queue model
        for (int c = 0; c < 40; c++) begin
            d0 = 48'({$urandom, $urandom});
            d1 = 48'({$urandom, $urandom});
            wr(2'($urandom_range(0, 3)), d0, d1);
            rd_ready = 1'($urandom_range(0, 1));
            #1;
            mspace = 16 - q.size();
            mpop   = (q.size() != 0) && rd_ready;
            if (mpop) begin
                chk("rnd_data", rd_data, q[0]);
                void'(q.pop_front());
            end
            macc = 0;
            if (wr_en[0] && macc < mspace) begin
                q.push_back(d0);
                macc++;
            end
            if (wr_en[1] && macc < mspace) begin
                q.push_back(d1);
                macc++;
            end
            tick();
            chk("rnd_count", count, q.size());
        end

        // reset mid-stream
        resetn = 1'b0;
        wr(2'b11, 48'd9, 48'd9);
        tick();
        resetn = 1'b1;
        wr(2'b00, '0, '0);
        rd_ready = 1'b0;
        chk("rst_cnt", count, 0);
        chk("rst_valid", rd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
